pulse_event_scheduler: RTL and testbench

- Monitors N_CH single-bit inputs with one rising/falling-edge classifier FSM per channel.
- Each completed high pulse is classified as a one-cycle pulse (010) or a long pulse, and its width is measured.
- Completed events are held in a 1-deep pending slot per channel.
- A round-robin scheduler shares a single valid/ready event output port between all channels, for downstream logging or interrupt logic.

---
 rtl/pulse_sched_pkg.sv | 28 ++
 rtl/pulse_classifier.sv | 74 +++++++
 rtl/pulse_event_scheduler.sv | 154 +++++++++++++++
 tb/tb_pulse_event_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse event scheduler.
// Contents:
//   ev_kind_e   - event classification (one-cycle pulse vs long pulse)
//   cls_state_e - per-channel classifier state
//   pend_t      - one pending-event slot (valid, kind, measured width)
// The width field of pend_t is sized for the widest supported counter
// (MAX_WIDTH_W); instances using a narrower WIDTH_W only fill the low bits.
package pulse_sched_pkg;

  localparam int MAX_WIDTH_W = 16;

  typedef enum logic {
    EV_ONE_CYCLE = 1'b0,
    EV_LONG      = 1'b1
  } ev_kind_e;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } cls_state_e;

  typedef struct packed {
    logic                   valid;
    ev_kind_e               kind;
    logic [MAX_WIDTH_W-1:0] width;
  } pend_t;

endpackage

// File: rtl/pulse_classifier.sv
// Per-channel high-pulse classifier.
// Tracks one input bit with a LOW/HIGH FSM and a saturating width counter.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   a             - monitored input bit
//   en            - channel enable; low forces the FSM idle and discards
//                   any partial pulse
//   emit          - one-cycle strobe, high in the cycle whose edge sees the
//                   falling edge of a completed pulse
//   kind, width   - classification and measured width, valid with emit
module pulse_classifier
  import pulse_sched_pkg::*;
#(
  parameter int WIDTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a,
  input  logic               en,
  output logic               emit,
  output ev_kind_e           kind,
  output logic [WIDTH_W-1:0] width
);

  localparam logic [WIDTH_W-1:0] CNT_MAX = '1;

  cls_state_e         state;
  logic [WIDTH_W-1:0] cnt;

  function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else if (!en) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      case (state)
        ST_LOW: begin
          // An input already high here (e.g. right after reset or
          // re-enable) is treated as a fresh rising edge.
          if (a) begin
            state <= ST_HIGH;
            cnt   <= WIDTH_W'(1);
          end
        end
        ST_HIGH: begin
          if (a) begin
            cnt <= sat_inc(cnt);
          end else begin
            state <= ST_LOW;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The event must land in the pending slot on the same edge that samples
  // the falling input, so the strobe is decoded from the current state and
  // the live input rather than registered.
  assign emit  = rst_n && en && (state == ST_HIGH) && !a;
  assign kind  = (cnt > WIDTH_W'(1)) ? EV_LONG : EV_ONE_CYCLE;
  assign width = cnt;

endmodule

// File: rtl/pulse_event_scheduler.sv
// Pulse event scheduler.
// Classifies completed high pulses on N_CH inputs, parks each event in a
// one-deep per-channel pending slot, and drains the slots round-robin
// through a single registered valid/ready event port.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   a[N_CH]               - monitored inputs
//   chan_en[N_CH]         - per-channel enables
//   ev_valid / ev_ready   - event handshake
//   ev_chan, ev_kind,
//   ev_width              - event payload (stable while stalled)
//   ovf[N_CH]             - sticky "event dropped" flags
//   ovf_clr               - clears all ovf bits (a same-edge set wins)
module pulse_event_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         a,
  input  logic [N_CH-1:0]         chan_en,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_CH)-1:0] ev_chan,
  output logic                    ev_kind,
  output logic [WIDTH_W-1:0]      ev_width,
  output logic [N_CH-1:0]         ovf,
  input  logic                    ovf_clr
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]    emit;
  ev_kind_e           cls_kind  [N_CH];
  logic [WIDTH_W-1:0] cls_width [N_CH];

  pend_t              pend [N_CH];
  logic [CH_W-1:0]    rr;

  logic               load;
  logic               found;
  logic [CH_W-1:0]    grant;
  logic [N_CH-1:0]    pend_clr;
  logic [N_CH-1:0]    ovf_set;

  // ---- Classifiers: one FSM per channel ----
  for (genvar g = 0; g < N_CH; g++) begin : g_cls
    pulse_classifier #(
      .WIDTH_W (WIDTH_W)
    ) u_cls (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a[g]),
      .en    (chan_en[g]),
      .emit  (emit[g]),
      .kind  (cls_kind[g]),
      .width (cls_width[g])
    );
  end

  // Only the low WIDTH_W bits of each slot's width are ever written; the
  // upper bits are folded into a dead signal so they count as consumed.
  if (WIDTH_W < MAX_WIDTH_W) begin : g_width_hi
    logic unused_width_hi;
    always_comb begin
      unused_width_hi = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        unused_width_hi = unused_width_hi | (|pend[i].width[MAX_WIDTH_W-1:WIDTH_W]);
      end
    end
  end

  // ---- Round-robin arbiter ----
  assign load = !ev_valid || ev_ready;

  always_comb begin
    int              idx;
    logic [CH_W-1:0] sel;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    sel   = '0;
    // Scan starting at rr and wrapping; the first pending slot wins.
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      sel = CH_W'(idx);
      if (!found && pend[sel].valid) begin
        found = 1'b1;
        grant = sel;
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    ovf_set  = '0;
    for (int i = 0; i < N_CH; i++) begin
      pend_clr[i] = load && found && (grant == CH_W'(i));
      // A slot being drained this edge has room for the new event.
      ovf_set[i]  = emit[i] && pend[i].valid && !pend_clr[i];
    end
  end

  // ---- Pending slots ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (emit[i] && !ovf_set[i]) begin
          pend[i] <= '{1'b1, cls_kind[i], MAX_WIDTH_W'(cls_width[i])};
        end else if (pend_clr[i]) begin
          pend[i].valid <= 1'b0;
        end
      end
    end
  end

  // ---- Sticky overflow flags ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
    end
  end

  // ---- Output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_kind  <= 1'b0;
      ev_width <= '0;
      rr       <= '0;
    end else if (load) begin
      if (found) begin
        ev_valid <= 1'b1;
        ev_chan  <= grant;
        ev_kind  <= pend[grant].kind;
        ev_width <= pend[grant].width[WIDTH_W-1:0];
        rr       <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Directed self-checking bench for pulse_event_scheduler.
// Main instance: N_CH=4, WIDTH_W=8. Second instance: N_CH=2, WIDTH_W=3,
// used for counter saturation.
module tb_pulse_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] chan_en;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_chan;
  logic       ev_kind;
  logic [7:0] ev_width;
  logic [3:0] ovf;
  logic       ovf_clr;

  logic [1:0] a_s;
  logic [1:0] chan_en_s;
  logic       ev_valid_s;
  logic       ev_ready_s;
  logic       ev_chan_s;
  logic       ev_kind_s;
  logic [2:0] ev_width_s;
  logic [1:0] ovf_s;
  logic       ovf_clr_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pulse_event_scheduler #(.N_CH(4), .WIDTH_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .chan_en  (chan_en),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_kind  (ev_kind),
    .ev_width (ev_width),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  pulse_event_scheduler #(.N_CH(2), .WIDTH_W(3)) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_s),
    .chan_en  (chan_en_s),
    .ev_valid (ev_valid_s),
    .ev_ready (ev_ready_s),
    .ev_chan  (ev_chan_s),
    .ev_kind  (ev_kind_s),
    .ev_width (ev_width_s),
    .ovf      (ovf_s),
    .ovf_clr  (ovf_clr_s)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit
  // after the posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // High for w sampled edges, then return after the edge that sees the fall.
  task automatic pulse(input int ch, input int w);
    a[ch] = 1'b1;
    repeat (w) tick();
    a[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = '0; chan_en = '1; ev_ready = 1'b1; ovf_clr = 1'b0;
    a_s = '0; chan_en_s = '1; ev_ready_s = 1'b1; ovf_clr_s = 1'b0;
    repeat (2) tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %0b, want 0", ev_valid); else passed++;
    total++; if (ev_chan !== 2'd0) $display("FAIL reset_chan: got %0d, want 0", ev_chan); else passed++;
    total++; if (ev_width !== 8'd0 || ev_kind !== 1'b0) $display("FAIL reset_payload: got w=%0d k=%0b, want w=0 k=0", ev_width, ev_kind); else passed++;
    total++; if (ovf !== 4'b0000) $display("FAIL reset_ovf: got %b, want 0000", ovf); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pulse();
    pulse(0, 1);
    total++; if (ev_valid !== 1'b0) $display("FAIL single_early: got valid=%0b one edge after fall, want 0", ev_valid); else passed++;
    tick();
    total++; if (ev_valid !== 1'b1) $display("FAIL single_valid: got %0b, want 1", ev_valid); else passed++;
    total++; if (ev_chan !== 2'd0) $display("FAIL single_chan: got %0d, want 0", ev_chan); else passed++;
    total++; if (ev_kind !== 1'b0 || ev_width !== 8'd1) $display("FAIL single_payload: got k=%0b w=%0d, want k=0 w=1", ev_kind, ev_width); else passed++;
    total++; if (ovf !== 4'b0000) $display("FAIL single_ovf: got %b, want 0000", ovf); else passed++;
    tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL single_drain: got valid=%0b, want 0", ev_valid); else passed++;
  endtask

  task automatic test_long_pulse();
    pulse(2, 5);
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2) $display("FAIL long_chan: got v=%0b ch=%0d, want v=1 ch=2", ev_valid, ev_chan); else passed++;
    total++; if (ev_kind !== 1'b1 || ev_width !== 8'd5) $display("FAIL long_payload: got k=%0b w=%0d, want k=1 w=5", ev_kind, ev_width); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    a_s[0] = 1'b1;
    repeat (12) tick();
    a_s[0] = 1'b0;
    tick();
    tick();
    total++; if (ev_valid_s !== 1'b1 || ev_chan_s !== 1'b0) $display("FAIL sat_valid: got v=%0b ch=%0d, want v=1 ch=0", ev_valid_s, ev_chan_s); else passed++;
    total++; if (ev_kind_s !== 1'b1 || ev_width_s !== 3'd7) $display("FAIL sat_width: got k=%0b w=%0d, want k=1 w=7", ev_kind_s, ev_width_s); else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    // Start from a known rr pointer of 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a = 4'b1111;
    tick();
    a = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ev_valid !== 1'b1 || ev_chan !== 2'(i) || ev_width !== 8'd1) $display("FAIL rr_burst%0d: got v=%0b ch=%0d w=%0d, want v=1 ch=%0d w=1", i, ev_valid, ev_chan, ev_width, i); else passed++;
    end
    tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL rr_idle: got valid=%0b, want 0", ev_valid); else passed++;
    a = 4'b1001;
    tick();
    a = 4'b0000;
    tick();
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd0) $display("FAIL rr_wrap_first: got v=%0b ch=%0d, want v=1 ch=0", ev_valid, ev_chan); else passed++;
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd3) $display("FAIL rr_wrap_second: got v=%0b ch=%0d, want v=1 ch=3", ev_valid, ev_chan); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    ev_ready = 1'b0;
    pulse(1, 1);
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd1 || ev_width !== 8'd1) $display("FAIL bp_first: got v=%0b ch=%0d w=%0d, want v=1 ch=1 w=1", ev_valid, ev_chan, ev_width); else passed++;
    pulse(1, 2);
    pulse(1, 3);
    total++; if (ovf !== 4'b0010) $display("FAIL bp_ovf_set: got %b, want 0010", ovf); else passed++;
    total++; if (ev_valid !== 1'b1 || ev_width !== 8'd1) $display("FAIL bp_stable: got v=%0b w=%0d, want v=1 w=1", ev_valid, ev_width); else passed++;
    ev_ready = 1'b1;
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd1 || ev_width !== 8'd2) $display("FAIL bp_second: got v=%0b ch=%0d w=%0d, want v=1 ch=1 w=2", ev_valid, ev_chan, ev_width); else passed++;
    tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL bp_third_dropped: got valid=%0b, want 0", ev_valid); else passed++;
    total++; if (ovf !== 4'b0010) $display("FAIL bp_ovf_sticky: got %b, want 0010", ovf); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 4'b0000) $display("FAIL bp_ovf_clr: got %b, want 0000", ovf); else passed++;
  endtask

  task automatic test_disable();
    a[3] = 1'b1;
    repeat (3) tick();
    chan_en[3] = 1'b0;
    tick();
    a[3] = 1'b0;
    repeat (3) tick();
    total++; if (ev_valid !== 1'b0 || ovf !== 4'b0000) $display("FAIL disable_no_event: got v=%0b ovf=%b, want v=0 ovf=0000", ev_valid, ovf); else passed++;
    chan_en[3] = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    pulse(1, 1);
    tick();
    a[0] = 1'b1;
    repeat (2) tick();
    total++; if (ev_valid !== 1'b1) $display("FAIL rstmid_pre: got valid=%0b, want 1", ev_valid); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    total++; if (ev_valid !== 1'b0 || ev_width !== 8'd0) $display("FAIL rstmid_clear: got v=%0b w=%0d, want v=0 w=0", ev_valid, ev_width); else passed++;
    repeat (3) tick();
    a[0] = 1'b0;
    tick();
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd0 || ev_width !== 8'd3 || ev_kind !== 1'b1) $display("FAIL rstmid_width: got v=%0b ch=%0d w=%0d k=%0b, want v=1 ch=0 w=3 k=1", ev_valid, ev_chan, ev_width, ev_kind); else passed++;
    tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL rstmid_drain: got valid=%0b, want 0", ev_valid); else passed++;
  endtask

  task automatic test_grant_emit_same_edge();
    ev_ready = 1'b0;
    pulse(0, 1);
    tick();
    pulse(2, 2);
    a[2] = 1'b1;
    repeat (3) tick();
    a[2] = 1'b0;
    ev_ready = 1'b1;
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2 || ev_width !== 8'd2) $display("FAIL same_edge_first: got v=%0b ch=%0d w=%0d, want v=1 ch=2 w=2", ev_valid, ev_chan, ev_width); else passed++;
    tick();
    total++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2 || ev_width !== 8'd3) $display("FAIL same_edge_second: got v=%0b ch=%0d w=%0d, want v=1 ch=2 w=3", ev_valid, ev_chan, ev_width); else passed++;
    total++; if (ovf !== 4'b0000) $display("FAIL same_edge_ovf: got %b, want 0000", ovf); else passed++;
    tick();
    total++; if (ev_valid !== 1'b0) $display("FAIL same_edge_drain: got valid=%0b, want 0", ev_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_long_pulse();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_disable();
    test_reset_mid();
    test_grant_emit_same_edge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
